// File: rtl/shift_test_pkg.sv
// ---------------------------------------------------------------------------
// shift_test_pkg
// Shared definitions for the shift-chain test sequencer:
//   - state_t        : sequencer FSM states
//   - PAT_*          : PATTERN_SEL codes
//   - DEFAULT_CNT_W  : default width of the error and pass counters
//   - pattern_bit()  : load/compare pattern bit for a given chain position
// ---------------------------------------------------------------------------
package shift_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    UNLOAD,
    REPORT
  } state_t;

  localparam logic [1:0] PAT_ONES  = 2'b00;
  localparam logic [1:0] PAT_ZEROS = 2'b01;
  localparam logic [1:0] PAT_ALT   = 2'b10;
  localparam logic [1:0] PAT_ALT_N = 2'b11;

  localparam int DEFAULT_CNT_W = 16;

  // Only the LSB of the chain position matters for every pattern, so the
  // caller passes just k[0].
  function automatic logic pattern_bit(input logic [1:0] sel, input logic k_lsb);
    logic b;
    case (sel)
      PAT_ONES:  b = 1'b1;
      PAT_ZEROS: b = 1'b0;
      PAT_ALT:   b = k_lsb;
      default:   b = ~k_lsb;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/shift_test_sequencer_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Synchronous-clear event counter, saturating at all-ones or wrapping.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear, wins over inc
//   inc        : count one event this cycle
//   count      : current value (CNT_W bits)
// Parameters:
//   CNT_W      : counter width
//   SATURATE   : 1 = hold at all-ones, 0 = wrap to zero
// ---------------------------------------------------------------------------
module sat_counter
  import shift_test_pkg::*;
#(
  parameter int CNT_W    = DEFAULT_CNT_W,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count register: clear beats increment; saturating flavour stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (!SATURATE || (count != '1))) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/shift_test_sequencer.sv
// ---------------------------------------------------------------------------
// shift_test_sequencer
// Radiation-style test sequencer for two DUT scan chains: loads a pattern,
// holds it static for a programmable exposure, unloads and compares, and
// counts upsets (SEU) and hold-phase output transients (SET).
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   run                     : start / keep running passes
//   clr_counts              : synchronous clear of every counter
//   pattern_sel[1:0]        : load pattern, latched when a pass starts
//   hold_cycles[15:0]       : hold length, latched when a pass starts
//   shift_out[1:0]          : tail outputs of DUT chains 0 and 1
//   shift_input[1:0]        : serial inputs of DUT chains 0 and 1
//   shift_en                : shift enable for both DUT chains
//   seu_count0/1            : unload mismatch counters (saturating)
//   set_count0/1            : hold transition counters (saturating)
//   pass_count              : completed passes (wrapping)
//   busy                    : sequencer not idle
//   pass_done               : one-cycle pulse in the report cycle
// Configuration macro:
//   SHIFT_TEST_SET_MON_EN   : when defined, SET monitoring is built in;
//                             otherwise set_count0/1 are tied to zero.
// ---------------------------------------------------------------------------
module shift_test_sequencer
  import shift_test_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr_counts,
  input  logic [1:0]       pattern_sel,
  input  logic [15:0]      hold_cycles,
  input  logic [1:0]       shift_out,
  output logic [1:0]       shift_input,
  output logic             shift_en,
  output logic [CNT_W-1:0] seu_count0,
  output logic [CNT_W-1:0] seu_count1,
  output logic [CNT_W-1:0] set_count0,
  output logic [CNT_W-1:0] set_count1,
  output logic [CNT_W-1:0] pass_count,
  output logic             busy,
  output logic             pass_done
);

  localparam logic [15:0] LOAD_LAST   = 16'(CHAIN_LEN - 1);
  localparam logic [15:0] UNLOAD_LAST = 16'(CHAIN_LEN);

  state_t      state;
  state_t      next_state;
  logic [15:0] cyc;
  logic [1:0]  pat_q;
  logic [15:0] hold_q;
  logic [1:0]  out_q;
  logic        latch_en;
  logic        exp_bit;
  logic [1:0]  seu_inc;

  // State register plus the in-phase cycle index, restarted on every phase change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cyc   <= '0;
    end else begin
      state <= next_state;
      if ((next_state != state) || (state == IDLE)) begin
        cyc <= '0;
      end else begin
        cyc <= cyc + 16'd1;
      end
    end
  end

  // Pattern and hold length are captured only when a pass starts, so the
  // inputs may change freely while a pass is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= '0;
      hold_q <= '0;
    end else if (latch_en) begin
      pat_q  <= pattern_sel;
      hold_q <= hold_cycles;
    end
  end

  // One retiming stage on the chain tails, running in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= shift_out;
    end
  end

  // Next-state and chain control. run is looked at only in IDLE and REPORT,
  // so dropping it mid-pass lets the pass finish.
  always_comb begin
    next_state  = state;
    latch_en    = 1'b0;
    shift_en    = 1'b0;
    shift_input = 2'b00;
    busy        = (state != IDLE);
    pass_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (run) begin
          next_state = LOAD;
          latch_en   = 1'b1;
        end
      end
      LOAD: begin
        shift_en    = 1'b1;
        shift_input = {2{pattern_bit(pat_q, cyc[0])}};
        if (cyc == LOAD_LAST) begin
          next_state = (hold_q == 16'd0) ? UNLOAD : HOLD;
        end
      end
      HOLD: begin
        if (cyc == hold_q - 16'd1) begin
          next_state = UNLOAD;
        end
      end
      UNLOAD: begin
        // The final unload cycle only compares the last bit; no shift.
        shift_en = (cyc != UNLOAD_LAST);
        if (cyc == UNLOAD_LAST) begin
          next_state = REPORT;
        end
      end
      REPORT: begin
        pass_done  = 1'b1;
        latch_en   = run;
        next_state = run ? LOAD : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Unload cycle j compares out_q against pattern bit j-1; (j-1)[0] is ~j[0].
  always_comb begin
    exp_bit = pattern_bit(pat_q, ~cyc[0]);
    seu_inc = 2'b00;
    if ((state == UNLOAD) && (cyc != 16'd0)) begin
      seu_inc = out_q ^ {2{exp_bit}};
    end
  end

  sat_counter #(.CNT_W(CNT_W), .SATURATE(1'b1)) u_seu0 (
    .clk(clk), .rst_n(rst_n), .clear(clr_counts), .inc(seu_inc[0]), .count(seu_count0)
  );

  sat_counter #(.CNT_W(CNT_W), .SATURATE(1'b1)) u_seu1 (
    .clk(clk), .rst_n(rst_n), .clear(clr_counts), .inc(seu_inc[1]), .count(seu_count1)
  );

  sat_counter #(.CNT_W(CNT_W), .SATURATE(1'b0)) u_pass (
    .clk(clk), .rst_n(rst_n), .clear(clr_counts), .inc(pass_done), .count(pass_count)
  );

`ifdef SHIFT_TEST_SET_MON_EN
  logic [1:0] out_prev;
  logic [1:0] set_inc;

  // Previous-cycle copy of out_q for hold-phase transition detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_prev <= '0;
    end else begin
      out_prev <= out_q;
    end
  end

  // The first hold cycle has no in-hold predecessor, so it never counts.
  assign set_inc = ((state == HOLD) && (cyc != 16'd0)) ? (out_q ^ out_prev) : 2'b00;

  sat_counter #(.CNT_W(CNT_W), .SATURATE(1'b1)) u_set0 (
    .clk(clk), .rst_n(rst_n), .clear(clr_counts), .inc(set_inc[0]), .count(set_count0)
  );

  sat_counter #(.CNT_W(CNT_W), .SATURATE(1'b1)) u_set1 (
    .clk(clk), .rst_n(rst_n), .clear(clr_counts), .inc(set_inc[1]), .count(set_count1)
  );
`else
  assign set_count0 = '0;
  assign set_count1 = '0;
`endif

endmodule

// File: tb/tb_shift_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_test_sequencer
// Drives the sequencer against two behavioural DUT chains with injectable
// faults (bit flip, output glitch, stuck-at-0 tail). Each started pass pushes
// its settings into a queue; a monitor pops an entry when the sequencer goes
// busy and predicts every output cycle by cycle from the pass rules.
// ---------------------------------------------------------------------------
module tb_shift_test_sequencer;

  localparam int L    = 8;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct {
    logic [1:0] pat;
    int         hold;
  } item_t;

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b0;
  logic          run         = 1'b0;
  logic          clr_counts  = 1'b0;
  logic [1:0]    pattern_sel = 2'b00;
  logic [15:0]   hold_cycles = 16'd0;
  logic [1:0]    shift_out;
  logic [1:0]    shift_input;
  logic          shift_en;
  logic [CW-1:0] seu_count0, seu_count1, set_count0, set_count1, pass_count;
  logic          busy, pass_done;

  int errors = 0;
  int checks = 0;

  // Behavioural DUT chains: index 0 is the tail, new bits enter at L-1.
  logic [L-1:0] chain0     = '0;
  logic [L-1:0] chain1     = '0;
  logic         stuck0     = 1'b0;
  logic [1:0]   glitch     = 2'b00;
  logic         flip_req   = 1'b0;
  int           flip_chain = 0;
  int           flip_pos   = 0;

  item_t      exp_q[$];
  logic [1:0] hist[$];

  assign shift_out = {chain1[0] ^ glitch[1], stuck0 ? 1'b0 : (chain0[0] ^ glitch[0])};

  shift_test_sequencer #(.CHAIN_LEN(L), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clr_counts(clr_counts),
    .pattern_sel(pattern_sel), .hold_cycles(hold_cycles), .shift_out(shift_out),
    .shift_input(shift_input), .shift_en(shift_en),
    .seu_count0(seu_count0), .seu_count1(seu_count1),
    .set_count0(set_count0), .set_count1(set_count1),
    .pass_count(pass_count), .busy(busy), .pass_done(pass_done)
  );

  always #5 clk = ~clk;

  // Chains shift when enabled; a requested flip lands on a non-shift edge.
  always @(posedge clk) begin
    if (shift_en) begin
      chain0 <= {shift_input[0], chain0[L-1:1]};
      chain1 <= {shift_input[1], chain1[L-1:1]};
    end else if (flip_req) begin
      if (flip_chain == 0) chain0[flip_pos] <= ~chain0[flip_pos];
      else                 chain1[flip_pos] <= ~chain1[flip_pos];
    end
  end

  function automatic logic patBit(input logic [1:0] p, input int k);
    case (p)
      2'b00:   return 1'b1;
      2'b01:   return 1'b0;
      2'b10:   return (k % 2) == 1;
      default: return (k % 2) == 0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, budget);
    end
  endtask

  // Monitor: reference model of outputs and counters, one step per cycle.
  initial begin : monitor
    item_t cur;
    bit    active = 1'b0;
    int    n = 0;
    int    m_seu[2];
    int    m_set[2];
    int    m_pass = 0;
    int    seu_inc[2];
    int    set_inc[2];
    int    pass_inc;
    int    last, j;
    logic  e_en;
    logic [1:0] e_in;
    m_seu = '{0, 0};
    m_set = '{0, 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_shift_en", int'(shift_en), 0);
        checkOutput("rst_shift_input", int'(shift_input), 0);
        checkOutput("rst_pass_done", int'(pass_done), 0);
        checkOutput("rst_counters", int'(seu_count0 | seu_count1 | set_count0 | set_count1 | pass_count), 0);
        exp_q.delete();
        hist.delete();
        active = 1'b0;
        m_seu  = '{0, 0};
        m_set  = '{0, 0};
        m_pass = 0;
      end else begin
        checkOutput("seu_count0", int'(seu_count0), m_seu[0]);
        checkOutput("seu_count1", int'(seu_count1), m_seu[1]);
        checkOutput("set_count0", int'(set_count0), m_set[0]);
        checkOutput("set_count1", int'(set_count1), m_set[1]);
        checkOutput("pass_count", int'(pass_count), m_pass);
        if (!active && busy && exp_q.size() > 0) begin
          cur    = exp_q.pop_front();
          active = 1'b1;
          n      = 0;
          hist.delete();
        end
        seu_inc  = '{0, 0};
        set_inc  = '{0, 0};
        pass_inc = 0;
        if (active) begin
          hist.push_back(shift_out);
          last = 2 * L + cur.hold + 1;
          e_in = 2'b00;
          if (n < L) begin
            e_en = 1'b1;
            e_in = {2{patBit(cur.pat, n)}};
          end else if (n < L + cur.hold) begin
            e_en = 1'b0;
          end else if (n < 2 * L + cur.hold) begin
            e_en = 1'b1;
          end else begin
            e_en = 1'b0;
          end
          checkOutput("busy", int'(busy), 1);
          checkOutput("shift_en", int'(shift_en), int'(e_en));
          checkOutput("shift_input", int'(shift_input), int'(e_in));
          checkOutput("pass_done", int'(pass_done), int'(n == last));
`ifdef SHIFT_TEST_SET_MON_EN
          if (n >= L + 1 && n < L + cur.hold) begin
            for (int i = 0; i < 2; i++) set_inc[i] = int'(hist[n-1][i] != hist[n-2][i]);
          end
`endif
          if (n >= L + cur.hold + 1 && n <= 2 * L + cur.hold) begin
            j = n - L - cur.hold;
            for (int i = 0; i < 2; i++) seu_inc[i] = int'(hist[n-1][i] != patBit(cur.pat, j - 1));
          end
          if (n == last) begin
            pass_inc = 1;
            active   = 1'b0;
          end
          n++;
        end else begin
          checkOutput("idle_busy", int'(busy), 0);
          checkOutput("idle_shift_en", int'(shift_en), 0);
          checkOutput("idle_shift_input", int'(shift_input), 0);
          checkOutput("idle_pass_done", int'(pass_done), 0);
        end
        if (clr_counts) begin
          m_seu  = '{0, 0};
          m_set  = '{0, 0};
          m_pass = 0;
        end else begin
          for (int i = 0; i < 2; i++) begin
            m_seu[i] = (m_seu[i] + seu_inc[i] > MAXC) ? MAXC : m_seu[i] + seu_inc[i];
            m_set[i] = (m_set[i] + set_inc[i] > MAXC) ? MAXC : m_set[i] + set_inc[i];
          end
          m_pass = (m_pass + pass_inc) % (MAXC + 1);
        end
      end
    end
  end

  // One pass from IDLE. kind: 0 none, 1 flip chain bit fpos in hold cycle 0,
  // 2 glitch tail in hold cycle fpos, 3 clear in unload cycle fpos,
  // 4 reset in unload cycle fpos.
  task automatic applyStimulus(input logic [1:0] pat, input int hold, input int kind,
                               input int fchain, input int fpos, input int pulse);
    int n  = 0;
    int tc = -1;
    waitIdle(400);
    pattern_sel = pat;
    hold_cycles = 16'(hold);
    exp_q.push_back('{pat: pat, hold: hold});
    run = 1'b1;
    tick();
    checkOutput("busy_at_load0", int'(busy), 1);
    for (int i = 1; i < pulse; i++) begin
      tick();
      n++;
    end
    run         = 1'b0;
    pattern_sel = 2'($urandom);
    hold_cycles = 16'($urandom_range(0, 9));
    case (kind)
      1:       tc = L;
      2:       tc = L + fpos;
      3, 4:    tc = L + hold + fpos;
      default: tc = -1;
    endcase
    if (tc >= 0) begin
      while (n < tc) begin
        tick();
        n++;
      end
      case (kind)
        1: begin
          flip_chain = fchain;
          flip_pos   = fpos;
          flip_req   = 1'b1;
          tick();
          flip_req   = 1'b0;
        end
        2: begin
          glitch[fchain] = 1'b1;
          tick();
          glitch = 2'b00;
        end
        3: begin
          clr_counts = 1'b1;
          tick();
          clr_counts = 1'b0;
        end
        default: begin
          rst_n = 1'b0;
          #1;
          checkOutput("async_rst_busy", int'(busy), 0);
          checkOutput("async_rst_shift_en", int'(shift_en), 0);
          checkOutput("async_rst_seu0", int'(seu_count0), 0);
          checkOutput("async_rst_pass", int'(pass_count), 0);
          tick();
          tick();
          rst_n = 1'b1;
          tick();
          checkOutput("post_rst_seu0", int'(seu_count0), 0);
          checkOutput("post_rst_busy", int'(busy), 0);
        end
      endcase
    end
    waitIdle(400);
  endtask

  // npass back-to-back passes with run held high throughout.
  task automatic runHeld(input logic [1:0] pat, input int hold, input int npass);
    int seen = 0;
    int k;
    waitIdle(400);
    pattern_sel = pat;
    hold_cycles = 16'(hold);
    for (int p = 0; p < npass; p++) exp_q.push_back('{pat: pat, hold: hold});
    run = 1'b1;
    while (seen < npass - 1) begin
      k = 0;
      do begin
        tick();
        k++;
      end while (!pass_done && k < 200);
      if (!pass_done) begin
        checks++;
        errors++;
        $display("[TB] FAIL pass_done_timeout: pass_done=%0b after %0d cycles, required 1", pass_done, k);
        break;
      end
      seen++;
    end
    tick();
    run = 1'b0;
    waitIdle(400);
  endtask

  initial begin : watchdog
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [1:0] pat;
    int hold, kind, fchain, fpos;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] directed passes");
    applyStimulus(2'b10, 4, 0, 0, 0, 1);
    applyStimulus(2'b10, 4, 1, 1, 3, 1);
    applyStimulus(2'b00, 4, 2, 0, 1, 1);

    $display("[TB] randomized passes");
    for (int r = 0; r < 14; r++) begin
      pat  = 2'($urandom);
      hold = $urandom_range(0, 6);
      kind = $urandom_range(0, 2);
      if (hold == 0) kind = 0;
      fchain = $urandom_range(0, 1);
      fpos   = (kind == 2) ? $urandom_range(0, hold - 1) : $urandom_range(0, L - 1);
      applyStimulus(pat, hold, kind, fchain, fpos, $urandom_range(1, 3));
    end

    $display("[TB] stuck-at-0 chain 0, back-to-back, saturation and wrap");
    stuck0 = 1'b1;
    runHeld(2'b00, 0, 260);

    $display("[TB] clear coincident with mismatch");
    applyStimulus(2'b00, 2, 3, 0, 4, 1);

    $display("[TB] reset mid-unload");
    applyStimulus(2'b00, 1, 4, 0, 5, 1);
    stuck0 = 1'b0;

    applyStimulus(2'b11, 3, 0, 0, 0, 2);
    repeat (3) tick();
    checkOutput("final_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
